// File: rtl/tx_lane_striper_pkg.sv
// Shared types and constants for the PHY TX striping path.
// Holds the FSM state type, the 8b/10b K-code symbols used on the TX lanes,
// and the link-width clamp helper used when a word is accepted.
package pl_tx_pkg;

  // Striper FSM: idle, or walking the beats of a latched word
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  // Control symbols that may appear on a TX lane with K=1
  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_PAD = 8'hF7;

  // Filler used for lane slots past the last valid symbol of a word
  localparam logic [7:0] PAD_SYM_DEFAULT = K_PAD;

  // Turn a requested log2 lane count into one the PHY can actually drive;
  // anything wider than the physical lane count runs at full width.
  function automatic int clamp_width(input int cfg, input int max_log2);
    return (cfg > max_log2) ? max_log2 : cfg;
  endfunction

endpackage

// File: rtl/tx_lane_striper_lane_beat_mux.sv
// Combinational lane mapper for the TX striper.
// Given a latched symbol word, the current beat index, the active lane count
// (as log2) and the index of the last valid symbol, produces the per-lane
// symbols, K flags and valids for that beat. Slots past the last symbol are
// padded; lanes beyond the active width are left idle. With lane reversal
// requested, logical lane j appears on physical lane N-1-j.
module lane_beat_mux
  import pl_tx_pkg::*;
#(
  parameter int                      MAX_LANES        = 32,
  parameter int                      SYMBOL_WIDTH     = 8,
  parameter int                      DATA_WIDTH       = MAX_LANES * SYMBOL_WIDTH,
  parameter int                      SYMBOL_PTR_WIDTH = (MAX_LANES > 1) ? $clog2(MAX_LANES) : 1,
  parameter int                      CFG_WIDTH        = 3,
  parameter logic [SYMBOL_WIDTH-1:0] PAD_SYM          = SYMBOL_WIDTH'(PAD_SYM_DEFAULT)
) (
  input  logic [0:DATA_WIDTH-1]       word_data,
  input  logic [0:MAX_LANES-1]        word_k,
  input  logic [SYMBOL_PTR_WIDTH-1:0] last_sym,
  input  logic [SYMBOL_PTR_WIDTH-1:0] beat_cnt,
  input  logic [CFG_WIDTH-1:0]        log2n,
  input  logic                        lane_rev,
  output logic [0:DATA_WIDTH-1]       lane_data,
  output logic [0:MAX_LANES-1]        lane_k,
  output logic [0:MAX_LANES-1]        lane_valid
);

  logic [SYMBOL_WIDTH-1:0] word_sym [MAX_LANES];
  int                      lane_cnt;
  int                      logical_lane;
  int                      sym_idx;

  // Unpack the flat word into a symbol array so it can be indexed by position
  always_comb begin
    for (int s = 0; s < MAX_LANES; s++) begin
      word_sym[s] = word_data[s*SYMBOL_WIDTH +: SYMBOL_WIDTH];
    end
  end

  // Pick, for every physical lane, the symbol this beat places on it
  always_comb begin
    lane_data    = '0;
    lane_k       = '0;
    lane_valid   = '0;
    lane_cnt     = 1 << log2n;
    logical_lane = 0;
    sym_idx      = 0;
    for (int p = 0; p < MAX_LANES; p++) begin
      if (p < lane_cnt) begin
        logical_lane  = lane_rev ? (lane_cnt - 1 - p) : p;
        sym_idx       = (int'(beat_cnt) << log2n) + logical_lane;
        lane_valid[p] = 1'b1;
        if (sym_idx > int'(last_sym)) begin
          lane_data[p*SYMBOL_WIDTH +: SYMBOL_WIDTH] = PAD_SYM;
          lane_k[p]                                 = 1'b1;
        end else begin
          lane_data[p*SYMBOL_WIDTH +: SYMBOL_WIDTH] = word_sym[SYMBOL_PTR_WIDTH'(sym_idx)];
          lane_k[p]                                 = word_k[SYMBOL_PTR_WIDTH'(sym_idx)];
        end
      end
    end
  end

endmodule

// File: rtl/tx_lane_striper.sv
// TX byte-striping stage between the framing/OS mux and the PIPE TX lanes.
// Accepts one full-width symbol word per handshake and sends it over 1..MAX_LANES
// active lanes, one beat per cycle that the downstream accepts. Narrow links
// need several beats per word, so upstream is back-pressured via o_ready; the
// last beat of a word can overlap the acceptance of the next one.
// Optional build macro LANE_REVERSAL_EN adds i_lane_rev, which mirrors the
// logical lane order across the active lanes for the word it is latched with.
module tx_lane_striper
  import pl_tx_pkg::*;
#(
  parameter int                      MAX_LANES        = 32,
  parameter int                      SYMBOL_WIDTH     = 8,
  parameter int                      DATA_WIDTH       = MAX_LANES * SYMBOL_WIDTH,
  parameter int                      SYMBOL_PTR_WIDTH = (MAX_LANES > 1) ? $clog2(MAX_LANES) : 1,
  parameter int                      CFG_WIDTH        = 3,
  parameter logic [SYMBOL_WIDTH-1:0] PAD_SYM          = SYMBOL_WIDTH'(PAD_SYM_DEFAULT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_soft_rst,
  input  logic [CFG_WIDTH-1:0]        i_cfg_width,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [0:DATA_WIDTH-1]       i_data,
  input  logic [0:MAX_LANES-1]        i_k,
  input  logic [SYMBOL_PTR_WIDTH-1:0] i_last_sym,
  input  logic                        i_tx_ready,
`ifdef LANE_REVERSAL_EN
  input  logic                        i_lane_rev,
`endif
  output logic [0:DATA_WIDTH-1]       o_data,
  output logic [0:MAX_LANES-1]        o_k,
  output logic [0:MAX_LANES-1]        o_lane_valid,
  output logic                        o_sob,
  output logic                        o_eow
);

  localparam int LOG2_LANES = $clog2(MAX_LANES);

  tx_state_e                   state_q, state_d;
  logic [SYMBOL_PTR_WIDTH-1:0] beat_q, beat_d;
  logic [0:DATA_WIDTH-1]       hold_data_q, hold_data_d;
  logic [0:MAX_LANES-1]        hold_k_q, hold_k_d;
  logic [SYMBOL_PTR_WIDTH-1:0] hold_last_q, hold_last_d;
  logic [CFG_WIDTH-1:0]        hold_log2n_q, hold_log2n_d;
  logic                        hold_rev_q, hold_rev_d;

  logic [CFG_WIDTH-1:0]        cfg_clamped;
  logic                        lane_rev_in;
  logic                        last_beat;
  logic                        accept;
  logic                        send_d;
  logic                        eow_d;

  logic [0:DATA_WIDTH-1]       mux_data;
  logic [0:MAX_LANES-1]        mux_k;
  logic [0:MAX_LANES-1]        mux_valid;

`ifdef LANE_REVERSAL_EN
  assign lane_rev_in = i_lane_rev;
`else
  assign lane_rev_in = 1'b0;
`endif

  assign cfg_clamped = CFG_WIDTH'(clamp_width(int'(i_cfg_width), LOG2_LANES));

  // The final beat of a word is beat floor(last_sym/N)
  assign last_beat = (beat_q == (hold_last_q >> hold_log2n_q));

  // Ready when idle, or when the final beat leaves this cycle so the next word
  // can follow without a gap
  assign o_ready = (state_q == IDLE) | ((state_q == SEND) & last_beat & i_tx_ready);
  assign accept  = i_valid & o_ready;

  // Next-state, beat counter and holding register updates
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    hold_data_d  = hold_data_q;
    hold_k_d     = hold_k_q;
    hold_last_d  = hold_last_q;
    hold_log2n_d = hold_log2n_q;
    hold_rev_d   = hold_rev_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = SEND;
          beat_d       = '0;
          hold_data_d  = i_data;
          hold_k_d     = i_k;
          hold_last_d  = i_last_sym;
          hold_log2n_d = cfg_clamped;
          hold_rev_d   = lane_rev_in;
        end
      end
      SEND: begin
        if (i_tx_ready) begin
          if (!last_beat) begin
            beat_d = beat_q + 1'b1;
          end else if (accept) begin
            state_d      = SEND;
            beat_d       = '0;
            hold_data_d  = i_data;
            hold_k_d     = i_k;
            hold_last_d  = i_last_sym;
            hold_log2n_d = cfg_clamped;
            hold_rev_d   = lane_rev_in;
          end else begin
            state_d = IDLE;
            beat_d  = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  assign send_d = (state_d == SEND);
  assign eow_d  = (beat_d == (hold_last_d >> hold_log2n_d));

  // Lane contents are computed for the beat that will be on the wire next cycle
  lane_beat_mux #(
    .MAX_LANES        (MAX_LANES),
    .SYMBOL_WIDTH     (SYMBOL_WIDTH),
    .DATA_WIDTH       (DATA_WIDTH),
    .SYMBOL_PTR_WIDTH (SYMBOL_PTR_WIDTH),
    .CFG_WIDTH        (CFG_WIDTH),
    .PAD_SYM          (PAD_SYM)
  ) u_lane_beat_mux (
    .word_data  (hold_data_d),
    .word_k     (hold_k_d),
    .last_sym   (hold_last_d),
    .beat_cnt   (beat_d),
    .log2n      (hold_log2n_d),
    .lane_rev   (hold_rev_d),
    .lane_data  (mux_data),
    .lane_k     (mux_k),
    .lane_valid (mux_valid)
  );

  // FSM state, beat counter and holding register; soft flush wins over everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      hold_data_q  <= '0;
      hold_k_q     <= '0;
      hold_last_q  <= '0;
      hold_log2n_q <= '0;
      hold_rev_q   <= 1'b0;
    end else if (i_soft_rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      hold_data_q  <= '0;
      hold_k_q     <= '0;
      hold_last_q  <= '0;
      hold_log2n_q <= '0;
      hold_rev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      hold_data_q  <= hold_data_d;
      hold_k_q     <= hold_k_d;
      hold_last_q  <= hold_last_d;
      hold_log2n_q <= hold_log2n_d;
      hold_rev_q   <= hold_rev_d;
    end
  end

  // Registered lane outputs; they only change when the beat advances, so a
  // stalled downstream sees a stable beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_data       <= '0;
      o_k          <= '0;
      o_lane_valid <= '0;
      o_sob        <= 1'b0;
      o_eow        <= 1'b0;
    end else if (i_soft_rst) begin
      o_data       <= '0;
      o_k          <= '0;
      o_lane_valid <= '0;
      o_sob        <= 1'b0;
      o_eow        <= 1'b0;
    end else begin
      o_data       <= send_d ? mux_data  : '0;
      o_k          <= send_d ? mux_k     : '0;
      o_lane_valid <= send_d ? mux_valid : '0;
      o_sob        <= send_d & (beat_d == '0);
      o_eow        <= send_d & eow_d;
    end
  end

endmodule

// File: tb/tb_tx_lane_striper.sv
// Scoreboard bench for tx_lane_striper: the driver pushes the expected beats
// of every accepted word, a negedge monitor compares the DUT lanes against
// the head of the queue and pops it when the downstream takes the beat.
module tb_tx_lane_striper;

  localparam int ML = 32;
  localparam int SW = 8;
  localparam int DW = ML * SW;
  localparam int PW = 5;
  localparam int CW = 3;
  localparam logic [7:0] PAD = 8'hF7;
`ifdef LANE_REVERSAL_EN
  localparam bit REV_EN = 1'b1;
`else
  localparam bit REV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_soft_rst = 1'b0;
  logic [CW-1:0] i_cfg_width = '0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [0:DW-1] i_data = '0;
  logic [0:ML-1] i_k = '0;
  logic [PW-1:0] i_last_sym = '0;
  logic          i_tx_ready = 1'b1;
`ifdef LANE_REVERSAL_EN
  logic          i_lane_rev = 1'b0;
`endif
  logic [0:DW-1] o_data;
  logic [0:ML-1] o_k;
  logic [0:ML-1] o_lane_valid;
  logic          o_sob;
  logic          o_eow;

  tx_lane_striper dut (
    .clk          (clk),
    .rst          (rst),
    .i_soft_rst   (i_soft_rst),
    .i_cfg_width  (i_cfg_width),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data       (i_data),
    .i_k          (i_k),
    .i_last_sym   (i_last_sym),
    .i_tx_ready   (i_tx_ready),
`ifdef LANE_REVERSAL_EN
    .i_lane_rev   (i_lane_rev),
`endif
    .o_data       (o_data),
    .o_k          (o_k),
    .o_lane_valid (o_lane_valid),
    .o_sob        (o_sob),
    .o_eow        (o_eow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:DW-1] data;
    logic [0:ML-1] k;
    logic [0:ML-1] valid;
    logic          sob;
    logic          eow;
  } beat_t;

  beat_t      exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         rdy_mode = 0;
  logic [7:0] w_sym [ML];
  bit         w_k [ML];

  function automatic void checkOutput(string name, logic [DW-1:0] act, logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endfunction

  // Reference model: split the word into ceil((last+1)/N) beats of N lanes
  task automatic push_word(int cfg, int last, bit rev);
    int    n;
    int    nb;
    int    j;
    int    s;
    beat_t bt;
    n  = (cfg >= 5) ? 32 : (1 << cfg);
    nb = last / n + 1;
    for (int b = 0; b < nb; b++) begin
      bt.data  = '0;
      bt.k     = '0;
      bt.valid = '0;
      for (int p = 0; p < n; p++) begin
        j = rev ? (n - 1 - p) : p;
        s = b * n + j;
        bt.valid[p] = 1'b1;
        if (s <= last) begin
          bt.data[p*SW +: SW] = w_sym[s];
          bt.k[p]             = w_k[s];
        end else begin
          bt.data[p*SW +: SW] = PAD;
          bt.k[p]             = 1'b1;
        end
      end
      bt.sob = (b == 0);
      bt.eow = (b == nb - 1);
      exp_q.push_back(bt);
    end
  endtask

  // Monitor: one check set per cycle, away from the active edge
  always @(negedge clk) begin
    beat_t e;
    if (exp_q.size() == 0) begin
      checkOutput("idle_ctrl", DW'({o_lane_valid, o_k, o_sob, o_eow}), '0);
      checkOutput("idle_data", DW'(o_data), '0);
      checkOutput("idle_ready", DW'(o_ready), DW'(1'b1));
    end else begin
      e = exp_q[0];
      checkOutput("beat_data", DW'(o_data), DW'(e.data));
      checkOutput("beat_k", DW'(o_k), DW'(e.k));
      checkOutput("beat_valid", DW'(o_lane_valid), DW'(e.valid));
      checkOutput("beat_sob_eow", DW'({o_sob, o_eow}), DW'({e.sob, e.eow}));
      checkOutput("beat_ready", DW'(o_ready), DW'(e.eow & i_tx_ready));
      if (i_tx_ready) void'(exp_q.pop_front());
    end
  end

  // Advance to just after the next rising edge and refresh downstream ready
  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: i_tx_ready = 1'b1;
      1: i_tx_ready = ($urandom_range(0, 3) != 0);
      default: ;
    endcase
  endtask

  // Offer one word until it is accepted; called just after a rising edge
  task automatic applyStimulus(int cfg, int last, bit rev, bit ramp);
    bit acc;
    int guard;
    acc   = 1'b0;
    guard = 0;
    for (int s = 0; s < ML; s++) begin
      w_sym[s] = ramp ? 8'(s) : 8'($urandom);
      w_k[s]   = ramp ? 1'b0 : 1'($urandom_range(0, 1));
      i_data[s*SW +: SW] = w_sym[s];
      i_k[s]             = w_k[s];
    end
    i_cfg_width = CW'(cfg);
    i_last_sym  = PW'(last);
`ifdef LANE_REVERSAL_EN
    i_lane_rev  = rev;
`endif
    i_valid     = 1'b1;
    while (!acc && guard < 400) begin
      #8;
      if (i_valid && o_ready && !i_soft_rst && rst) begin
        acc = 1'b1;
        push_word(cfg, last, rev);
      end
      tick();
      guard++;
    end
    i_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL accept_timeout: got o_ready stuck low, expected accept within 400 cycles");
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 1000) begin
      tick();
      g++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
    end
    tick();
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    checkOutput("reset_data", DW'(o_data), '0);
    checkOutput("reset_ctrl", DW'({o_lane_valid, o_k, o_sob, o_eow}), '0);
    checkOutput("reset_ready", DW'(o_ready), DW'(1'b1));
    #15 rst = 1'b1;
    tick();

    $display("[TB] x32 back-to-back words");
    rdy_mode = 0;
    applyStimulus(5, 31, 1'b0, 1'b0);
    applyStimulus(5, 31, 1'b0, 1'b0);
    drain();

    $display("[TB] x4 full word, x4 short padded word, clamped width");
    applyStimulus(2, 31, 1'b0, 1'b1);
    drain();
    applyStimulus(2, 9, 1'b0, 1'b0);
    drain();
    applyStimulus(7, 20, 1'b0, 1'b0);
    drain();

    $display("[TB] x2 word with downstream stall on beat 1");
    rdy_mode   = 2;
    i_tx_ready = 1'b1;
    applyStimulus(1, 7, 1'b0, 1'b1);
    tick();
    i_tx_ready = 1'b0;
    repeat (3) tick();
    i_tx_ready = 1'b1;
    drain();

    $display("[TB] soft flush mid-word, then soft flush on an accept");
    rdy_mode = 0;
    applyStimulus(0, 5, 1'b0, 1'b0);
    tick();
    tick();
    i_soft_rst = 1'b1;
    tick();
    i_soft_rst = 1'b0;
    exp_q.delete();
    checkOutput("soft_flush_ctrl", DW'({o_lane_valid, o_sob, o_eow}), '0);
    checkOutput("soft_flush_ready", DW'(o_ready), DW'(1'b1));
    applyStimulus(0, 1, 1'b0, 1'b0);
    drain();
    i_soft_rst = 1'b1;
    i_valid    = 1'b1;
    tick();
    i_soft_rst = 1'b0;
    i_valid    = 1'b0;
    tick();

    $display("[TB] async reset mid-word");
    applyStimulus(0, 10, 1'b0, 1'b0);
    tick();
    tick();
    #1 rst = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("async_rst_ctrl", DW'({o_lane_valid, o_k, o_sob, o_eow}), '0);
    checkOutput("async_rst_data", DW'(o_data), '0);
    checkOutput("async_rst_ready", DW'(o_ready), DW'(1'b1));
    #4 rst = 1'b1;
    tick();
    applyStimulus(1, 3, 1'b0, 1'b0);
    drain();

`ifdef LANE_REVERSAL_EN
    $display("[TB] lane reversal x4");
    applyStimulus(2, 3, 1'b1, 1'b1);
    drain();
`endif

    $display("[TB] randomized words with random downstream stalls");
    rdy_mode = 1;
    repeat (150) begin
      applyStimulus($urandom_range(0, 7), $urandom_range(0, 31),
                    REV_EN & 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rdy_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tx_lane_striper.md
Name: tx_lane_striper

Overview:
Parametrised TX byte-striping stage for the physical layer, placed between the framing/OS mux and the PIPE TX lanes. It accepts one full-width symbol word per handshake and distributes it across a run-time selectable link width (x1..xMAX_LANES). Narrow links take multiple beats per word, so the block back-pressures upstream. It generalises the fixed 32-lane TX path: it adds link-width modes, short-word padding with PAD K-codes and a downstream stall.

Parameters:
MAX_LANES, 32, physical lane count; must be a power of 2, from 1 to 32.
SYMBOL_WIDTH, 8, bits per symbol.
DATA_WIDTH, MAX_LANES*SYMBOL_WIDTH, input word width.
SYMBOL_PTR_WIDTH, 5, equal to log2(MAX_LANES), with a minimum of 1.
CFG_WIDTH, 3, width of the link-width code.
PAD_SYM, 8'hF7, symbol used to fill unused slots on the last beat.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
i_soft_rst  in  1  synchronous flush, active-high
i_cfg_width  in  CFG_WIDTH  log2 of the active lane count N; values above log2(MAX_LANES) clamp to MAX_LANES
i_valid  in  1  input word valid
o_ready  out  1  block can accept a word
i_data  in  [0:DATA_WIDTH-1]  symbol word; symbol s occupies bits s*8..s*8+7
i_k  in  [0:MAX_LANES-1]  per-symbol K flag
i_last_sym  in  SYMBOL_PTR_WIDTH  index of the last valid symbol in the word
i_tx_ready  in  1  downstream accepts the current beat
o_data  out  [0:DATA_WIDTH-1]  per-lane symbols
o_k  out  [0:MAX_LANES-1]  per-lane K flag
o_lane_valid  out  [0:MAX_LANES-1]  per-lane valid
o_sob  out  1  first beat of a word
o_eow  out  1  last beat of a word

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, beat_cnt=0, holding register cleared. At reset: o_ready=1, o_data=0, o_k=0, o_lane_valid=0, o_sob=0, o_eow=0. i_soft_rst=1 gives the same result synchronously at the next edge and takes priority over every other input.
- Handshake: a word is accepted when i_valid & o_ready. The accept cycle latches i_data, i_k, i_last_sym and the clamped N. Configuration changes while a word is in flight are ignored.
- Beat count: B = floor(i_last_sym/N)+1.
- Beat k drives logical lane j (j<N) with symbol k*N+j.
  - If k*N+j > i_last_sym, the lane carries PAD_SYM with o_k=1.
  - Lanes j>=N have lane_valid=0, data=0, k=0.
- State machine:
  - IDLE: on accept, go to SEND with beat_cnt=0.
  - SEND: outputs are registered and hold stable while i_tx_ready=0. When i_tx_ready=1 and beat_cnt<B-1, beat_cnt increments. When i_tx_ready=1 and beat_cnt=B-1, the block returns to IDLE, or on the same edge accepts the next word and stays in SEND with beat_cnt=0.
- o_ready = (state==IDLE) | (state==SEND & beat_cnt==B-1 & i_tx_ready). This gives back-to-back words with no bubble.
- Latency: the first beat appears on the outputs in the cycle after accept. o_sob=1 only on beat 0; o_eow=1 only on beat B-1. When B=1 both are 1.
- o_lane_valid is all zeros in IDLE.
- beat_cnt width is SYMBOL_PTR_WIDTH. It never wraps, because B <= MAX_LANES.
- If i_soft_rst coincides with accept, the word is dropped.

Optional Feature:
Macro LANE_REVERSAL_EN.
- Defined: adds input port i_lane_rev (1 bit), latched on accept. When it is 1, logical lane j drives physical lane N-1-j within the active lanes, which applies to o_data, o_k and o_lane_valid. Lanes j>=N are unaffected.
- Undefined: the port is absent and the mapping is always identity.

Decomposition:
- Package pl_tx_pkg:
  - state enum {IDLE, SEND}
  - PAD_SYM default and K-code constants
  - function clamp_width(cfg) -> log2N
- Sub-module lane_beat_mux (combinational): maps the holding word, beat_cnt, N and last_sym to per-lane data, k and valid, including reversal. The top keeps only the FSM, counter and output registers.

Test Plan:
- cfg=5 (x32), last_sym=31, i_tx_ready=1, two back-to-back words -> one beat each with o_sob=o_eow=1, o_ready held 1, no bubble, all 32 lane_valid set.
- cfg=2 (x4), last_sym=31 -> 8 beats. Beat 3 drives lanes 0..3 with symbols 12..15, lanes 4..31 have valid=0, and o_ready=1 only during beat 7.
- cfg=2, last_sym=9 -> 3 beats. Beat 2 lanes 0,1 carry symbols 8,9; lanes 2,3 carry 8'hF7 with o_k=1; o_eow=1.
- cfg=1 (x2), i_tx_ready deasserted for 3 cycles during beat 1 -> outputs hold symbols 2,3 unchanged, then the sequence resumes; no symbol is lost.
- i_soft_rst pulsed during beat 2 of an x1 word, and a separate async rst asserted mid-word -> all outputs are 0 and o_ready=1 the next cycle (for rst: immediately), and the next word starts at o_sob.
- With LANE_REVERSAL_EN defined, cfg=2, i_lane_rev=1, symbols 0..3 -> physical lanes 3,2,1,0 carry symbols 0,1,2,3.
